// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one multi-cycle FPU between two requesters.
// Round-robin grant, operand latching, fpu_en sequencing so the FPU is never
// restarted or frozen mid-operation, a watchdog for hung operations, and a
// drain phase that walks the FPU back to its start state after reset/timeout.
//
// Handshake: a requester raises reqN with instrN/opaN/opbN and holds all of
// them stable until gntN is seen high; gntN is combinational and high for
// exactly one cycle (the cycle whose rising edge latches the operands).
// Nothing is queued: a request made while busy simply waits in IDLE.
// The response is a single-cycle rsp_valid strobe with rsp_id/rsp_data/rsp_err.
module fpu_arbiter #(
    parameter int TIMEOUT      = 15,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [4:0]  instr0,
    input  logic [15:0] opa0,
    input  logic [15:0] opb0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [4:0]  instr1,
    input  logic [15:0] opa1,
    input  logic [15:0] opb1,
    output logic        gnt1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        fpu_en,
    output logic [4:0]  fpu_instr,
    output logic [15:0] fpu_op1,
    output logic [15:0] fpu_op2,
    input  logic [15:0] fpu_result,
    input  logic        fpu_done
);

    // FTOI is a no-op when the FPU sits in its start state, so it is the
    // opcode used to clock the FPU forward while draining.
    localparam logic [4:0] OP_FTOI   = 5'h12;
    localparam logic [4:0] OP_FIRST  = 5'h11;
    localparam logic [4:0] OP_LAST   = 5'h16;
    localparam int         WD_W      = $clog2(TIMEOUT + 1);
    localparam int         DC_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_REJECT
    } state_t;

    state_t          state_q, state_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            last_id_q, last_id_d;
    logic            id_q, id_d;
    logic [4:0]      instr_q, instr_d;
    logic [15:0]     op1_q, op1_d;
    logic [15:0]     op2_q, op2_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            drain_after_q, drain_after_d;

    logic [WD_W-1:0] wd_next;
    logic [4:0]      sel_instr;
    logic            any_gnt;

    // State register and latched transaction context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_DRAIN;
            drain_cnt_q   <= '0;
            wd_cnt_q      <= '0;
            last_id_q     <= 1'b1;
            id_q          <= 1'b0;
            instr_q       <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            drain_after_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            last_id_q     <= last_id_d;
            id_q          <= id_d;
            instr_q       <= instr_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            drain_after_q <= drain_after_d;
        end
    end

    // Next-state logic, grants, FPU enable and response strobe.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        last_id_d     = last_id_q;
        id_d          = id_q;
        instr_d       = instr_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        drain_after_d = drain_after_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        fpu_en        = 1'b0;
        rsp_valid     = 1'b0;
        wd_next       = wd_cnt_q + WD_W'(1);
        sel_instr     = instr0;
        any_gnt       = 1'b0;

        case (state_q)
            S_DRAIN: begin
                fpu_en = 1'b1;
                if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            S_IDLE: begin
                // On a tie the requester that was not served last wins.
                gnt0    = req0 & (~req1 | last_id_q);
                gnt1    = req1 & (~req0 | ~last_id_q);
                any_gnt = gnt0 | gnt1;
                if (any_gnt) begin
                    sel_instr = gnt1 ? instr1 : instr0;
                    id_d      = gnt1;
                    last_id_d = gnt1;
                    instr_d   = sel_instr;
                    op1_d     = gnt1 ? opa1 : opa0;
                    op2_d     = gnt1 ? opb1 : opb0;
                    if (sel_instr >= OP_FIRST && sel_instr <= OP_LAST) begin
                        state_d = S_ISSUE;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_REJECT;
                    end
                end
            end
            S_ISSUE: begin
                // fpu_done may still be high from the previous op; ignore it.
                fpu_en   = 1'b1;
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Stop clocking the FPU the moment it reports completion.
                fpu_en = ~fpu_done;
                if (fpu_done) begin
                    rsp_data_d = fpu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    wd_cnt_d = wd_next;
                    if (wd_next == WD_W'(TIMEOUT)) begin
                        rsp_data_d    = '0;
                        rsp_err_d     = 1'b1;
                        drain_after_d = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (drain_after_q) begin
                    drain_after_d = 1'b0;
                    drain_cnt_d   = '0;
                    state_d       = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REJECT: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_DRAIN;
            end
        endcase
    end

    // FPU operand/opcode mux: a no-op during drain, latched values otherwise.
    always_comb begin
        fpu_instr = instr_q;
        fpu_op1   = op1_q;
        fpu_op2   = op2_q;
        if (state_q == S_DRAIN) begin
            fpu_instr = OP_FTOI;
            fpu_op1   = '0;
            fpu_op2   = '0;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rsp_id   = id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed bench for fpu_arbiter with a behavioural FPU,
// a cycle-level reference of the arbitration rules, and a response scoreboard.
module tb_fpu_arbiter;

    localparam int         TIMEOUT      = 15;
    localparam int         DRAIN_CYCLES = 3;
    localparam logic [4:0] OP_ADDF      = 5'h11;
    localparam logic [4:0] OP_FTOI      = 5'h12;
    localparam logic [4:0] OP_ITOF      = 5'h13;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  instr0 = '0, instr1 = '0;
    logic [15:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic        gnt0, gnt1;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [15:0] rsp_data;
    logic        fpu_en;
    logic [4:0]  fpu_instr;
    logic [15:0] fpu_op1, fpu_op2;
    logic [15:0] fpu_result = '0;
    logic        fpu_done   = 1'b0;

    fpu_arbiter #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .instr0(instr0), .opa0(opa0), .opb0(opb0), .gnt0(gnt0),
        .req1(req1), .instr1(instr1), .opa1(opa1), .opb1(opb1), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1),
        .fpu_op2(fpu_op2), .fpu_result(fpu_result), .fpu_done(fpu_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural FPU ----------------
    // int16 -> bfloat16 (truncating); ITOF takes a few enabled cycles, ITOF of
    // zero completes at once, ADDF is never completed, FTOI is a start-state no-op.
    function automatic logic [15:0] itof(input logic [15:0] v);
        logic        s;
        int          mag;
        int          p;
        logic [31:0] sh;
        s   = v[15];
        mag = s ? (65536 - int'(v)) : int'(v);
        if (mag == 0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) p = i;
        sh = 32'(mag) << (23 - p);
        return {s, 8'(127 + p), sh[22:16]};
    endfunction

    int          f_st = 0;
    logic [15:0] f_b  = '0;
    always @(posedge clk) begin
        if (fpu_en) begin
            case (f_st)
                0: begin
                    if (fpu_instr == OP_ITOF) begin
                        if (fpu_op2 == 16'h0000) begin
                            fpu_done   <= 1'b1;
                            fpu_result <= 16'h0000;
                        end else begin
                            fpu_done <= 1'b0;
                            f_b      <= fpu_op2;
                            f_st     <= 1;
                        end
                    end else begin
                        fpu_done <= 1'b0;
                    end
                end
                1: f_st <= 2;
                default: begin
                    f_st       <= 0;
                    fpu_done   <= 1'b1;
                    fpu_result <= itof(f_b);
                end
            endcase
        end
    end

    // ---------------- reference model of the arbitration rules ----------------
    int          m_drain = DRAIN_CYCLES, n_drain;
    bit          m_have = 0, n_have;
    int          m_age = 0, n_age;
    int          m_wait = 0, n_wait;
    bit          m_resp = 0, n_resp;
    bit          m_rerr = 0, n_rerr;
    logic [15:0] m_rdata = '0, n_rdata;
    bit          m_rid = 0, n_rid;
    bit          m_dafter = 0, n_dafter;
    bit          m_last = 1, n_last;
    logic [4:0]  m_instr = '0, n_instr;
    logic [15:0] m_a = '0, n_a, m_b = '0, n_b;
    bit          e_g0, e_g1, e_rv, e_busy, e_en;
    logic [4:0]  e_instr, g_instr;
    logic [15:0] e_a, e_b, g_a, g_b;
    int          w;

    // scoreboard entries: {id, err, data}
    logic [17:0] exp_q[$];
    logic [17:0] sb_e;

    always @(posedge clk) begin
        cyc++;
        m_drain = n_drain; m_have = n_have; m_age = n_age; m_wait = n_wait;
        m_resp = n_resp; m_rerr = n_rerr; m_rdata = n_rdata; m_rid = n_rid;
        m_dafter = n_dafter; m_last = n_last; m_instr = n_instr; m_a = n_a; m_b = n_b;
    end

    // Compare process: expected outputs for this cycle, then next model state.
    always @(negedge clk) begin
        n_drain = m_drain; n_have = m_have; n_age = m_age; n_wait = m_wait;
        n_resp = m_resp; n_rerr = m_rerr; n_rdata = m_rdata; n_rid = m_rid;
        n_dafter = m_dafter; n_last = m_last; n_instr = m_instr; n_a = m_a; n_b = m_b;
        e_g0 = 0; e_g1 = 0; e_rv = 0; e_busy = 1; e_en = 0;
        e_instr = m_instr; e_a = m_a; e_b = m_b;
        if (!rst_n) begin
            e_en = 1; e_instr = OP_FTOI; e_a = '0; e_b = '0;
            n_drain = DRAIN_CYCLES; n_have = 0; n_age = 0; n_wait = 0; n_resp = 0;
            n_rerr = 0; n_rdata = '0; n_rid = 0; n_dafter = 0; n_last = 1;
            n_instr = '0; n_a = '0; n_b = '0;
        end else if (m_drain > 0) begin
            e_en = 1; e_instr = OP_FTOI; e_a = '0; e_b = '0;
            n_drain = m_drain - 1;
        end else if (m_resp) begin
            e_rv   = 1;
            n_resp = 0;
            if (m_dafter) begin
                n_drain  = DRAIN_CYCLES;
                n_dafter = 0;
            end
        end else if (m_have) begin
            if (m_age == 0) begin
                e_en = 1; n_age = 1; n_wait = 0;
            end else begin
                e_en = !fpu_done;
                if (fpu_done) begin
                    n_have = 0; n_resp = 1; n_rerr = 0; n_rdata = fpu_result;
                end else begin
                    n_wait = m_wait + 1;
                    if (n_wait == TIMEOUT) begin
                        n_have = 0; n_resp = 1; n_rerr = 1; n_rdata = '0; n_dafter = 1;
                    end
                end
            end
        end else begin
            e_busy = 0;
            w = -1;
            if (req0 && req1) w = m_last ? 0 : 1;
            else if (req0) w = 0;
            else if (req1) w = 1;
            if (w >= 0) begin
                if (w == 0) begin
                    e_g0 = 1; g_instr = instr0; g_a = opa0; g_b = opb0;
                end else begin
                    e_g1 = 1; g_instr = instr1; g_a = opa1; g_b = opb1;
                end
                n_last = (w == 1); n_rid = (w == 1);
                n_instr = g_instr; n_a = g_a; n_b = g_b;
                if (g_instr >= 5'h11 && g_instr <= 5'h16) begin
                    n_have = 1; n_age = 0;
                end else begin
                    n_resp = 1; n_rerr = 1; n_rdata = '0;
                end
            end
        end
        chk("m_gnt0", 32'(gnt0), 32'(e_g0));
        chk("m_gnt1", 32'(gnt1), 32'(e_g1));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_fpu_en", 32'(fpu_en), 32'(e_en));
        chk("m_fpu_instr", 32'(fpu_instr), 32'(e_instr));
        chk("m_fpu_op1", 32'(fpu_op1), 32'(e_a));
        chk("m_fpu_op2", 32'(fpu_op2), 32'(e_b));
        if (e_rv) begin
            chk("m_rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("m_rsp_err", 32'(rsp_err), 32'(m_rerr));
            chk("m_rsp_data", 32'(rsp_data), 32'(m_rdata));
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_rsp", 32'({rsp_id, rsp_err, rsp_data}), 32'(sb_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit id, input logic [4:0] ins, input logic [15:0] b,
                        input logic [15:0] ed, input bit ee, output int gc);
        bit got;
        got = 0;
        gc  = -1;
        @(posedge clk); #1;
        if (id == 0) begin
            req0 = 1; instr0 = ins; opa0 = b ^ 16'h5A3C; opb0 = b;
        end else begin
            req1 = 1; instr1 = ins; opa1 = b ^ 16'hC3A5; opb1 = b;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) begin
                got = 1;
                gc  = cyc;
                exp_q.push_back({id, ee, ed});
                break;
            end
        end
        chk(id ? "gnt1_seen" : "gnt0_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic run1(input string nm, input bit id, input logic [4:0] ins,
                        input logic [15:0] b, input logic [15:0] ed, input bit ee,
                        input int el, input int een, output int gc);
        int lat;
        int en_cnt;
        lat    = -1;
        en_cnt = 0;
        send(id, ins, b, ed, ee, gc);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fpu_en) en_cnt++;
            if (rsp_valid) begin
                lat = cyc - gc;
                chk({nm, "_data"}, 32'(rsp_data), 32'(ed));
                chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
                chk({nm, "_id"}, 32'(rsp_id), 32'(id));
                break;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(el));
        chk({nm, "_fpu_en_cycles"}, 32'(en_cnt), 32'(een));
    endtask

    // ---------------- directed sequence ----------------
    int rel, ga0, ga1, gb0, gb1, g1, g2, seen;

    initial begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_fpu_en", 32'(fpu_en), 32'd1);
        chk("rst_fpu_instr", 32'(fpu_instr), 32'h12);
        chk("rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1;
        rel   = cyc;

        // Both requesters waiting when the drain ends: 0 first, then alternate.
        fork
            begin
                send(0, OP_ITOF, 16'h0028, 16'h4220, 0, ga0);
                send(0, OP_ITOF, 16'h0003, 16'h4040, 0, ga1);
            end
            begin
                send(1, OP_ITOF, 16'h0100, 16'h4380, 0, gb0);
                send(1, OP_ITOF, 16'hFFFF, 16'hBF80, 0, gb1);
            end
        join
        chk("arb_first_gnt0_after_drain", 32'(ga0 - rel), 32'd3);
        chk("arb_gnt1_second", 32'(gb0 - ga0), 32'd6);
        chk("arb_gnt0_third", 32'(ga1 - gb0), 32'd6);
        chk("arb_gnt1_fourth", 32'(gb1 - ga1), 32'd6);

        run1("itof_28", 0, OP_ITOF, 16'h0028, 16'h4220, 0, 5, 3, g1);
        run1("itof_zero", 1, OP_ITOF, 16'h0000, 16'h0000, 0, 3, 1, g1);
        run1("itof_m1", 0, OP_ITOF, 16'hFFFF, 16'hBF80, 0, 5, 3, g1);
        run1("reject", 1, 5'h08, 16'h1111, 16'h0000, 1, 1, 0, g1);

        // Watchdog: 15 WAIT cycles, error response, then a 3-cycle drain.
        run1("addf_timeout", 0, OP_ADDF, 16'h0028, 16'h0000, 1, 17, 16, g1);
        run1("after_timeout", 0, OP_ITOF, 16'h0028, 16'h4220, 0, 5, 3, g2);
        chk("timeout_drain_gap", 32'(g2 - g1), 32'd21);

        // Reset in cycle 3 of an ITOF: no response, drain, then normal service.
        send(0, OP_ITOF, 16'h0028, 16'h4220, 0, g1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        exp_q.delete();
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            @(posedge clk);
        end
        #1;
        rst_n = 1;
        rel   = cyc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("reset_no_rsp", 32'(seen), 32'd0);
        run1("after_reset", 0, OP_ITOF, 16'h0028, 16'h4220, 0, 5, 3, g2);
        chk("reset_drain_gap", 32'(g2 - rel), 32'd3);

        repeat (4) @(negedge clk);
        chk("sb_all_rsp_seen", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
